// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   tx_state_t : transmitter frame states
//   baud_div() : system clocks per bit (integer truncation)
//   START_BIT / STOP_BIT : line levels of the framing bits
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int baud_div(input int clk_frq, input int baud_rate);
        return clk_frq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter for the UART transmitter.
//   clk      : system clock
//   areset_n : asynchronous active-low reset
//   restart  : force the count back to 0 (held while the line is idle)
//   en       : advance the count by one
//   tick     : high during the cycle the count sits at DIV-1; the count
//              wraps to 0 on the following edge, so every bit lasts DIV cycles
module uart_baud_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic areset_n,
    input  logic restart,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             at_top;

    assign at_top = (cnt_reg == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_reg <= '0;
        end else if (restart) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= at_top ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    assign tick = en && !restart && at_top;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends start bit (0), BYTE data bits LSB
// first, then STOP_BITS stop bits (1), each BAUD_DIV clocks long.
//   clk      : system clock
//   areset_n : asynchronous active-low reset
//   tx_data  : byte to send, captured on the accept edge
//   tx_valid : tx_data is valid
//   tx_ready : transmitter is idle and will accept a byte
//   data_out : serial line, idles high
//   tx_busy  : a frame is in progress
//   tx_done  : one-cycle pulse as the last stop bit completes
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FRQ   = 250000000,
    parameter int BAUD_RATE = 115200,
    parameter int BYTE      = 8,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            areset_n,
    input  logic [BYTE-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            data_out,
    output logic            tx_busy,
    output logic            tx_done
);

    localparam int BAUD_DIV = baud_div(CLK_FRQ, BAUD_RATE);
    localparam int IDX_W    = (BYTE > 1) ? $clog2(BYTE) : 1;

    generate
        if (BAUD_DIV < 2) begin : g_bad_baud_div
            $error("uart_tx: CLK_FRQ/BAUD_RATE must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (BYTE < 1) begin : g_bad_byte
            $error("uart_tx: BYTE must be at least 1");
        end
    endgenerate

    tx_state_t        state_reg;
    logic [BYTE-1:0]  shift_reg;
    logic [BYTE-1:0]  shift_next;
    logic [IDX_W-1:0] bit_idx_reg;
    logic             stop_cnt_reg;
    logic             data_out_reg;
    logic             tx_done_reg;
    logic             idle;
    logic             baud_tick;

    assign idle       = (state_reg == IDLE);
    assign shift_next = shift_reg >> 1;

    // The bit timer sits at 0 while idle, so the accept edge starts a
    // fresh bit period aligned with the falling start edge.
    uart_baud_gen #(
        .DIV(BAUD_DIV)
    ) u_baud_gen (
        .clk     (clk),
        .areset_n(areset_n),
        .restart (idle),
        .en      (!idle),
        .tick    (baud_tick)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            data_out_reg <= STOP_BIT;
            tx_done_reg  <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    data_out_reg <= STOP_BIT;
                    if (tx_valid) begin
                        shift_reg    <= tx_data;
                        data_out_reg <= START_BIT;
                        state_reg    <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        data_out_reg <= shift_reg[0];
                        bit_idx_reg  <= '0;
                        state_reg    <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_idx_reg == IDX_W'(BYTE - 1)) begin
                            data_out_reg <= STOP_BIT;
                            stop_cnt_reg <= 1'b0;
                            state_reg    <= STOP;
                        end else begin
                            shift_reg    <= shift_next;
                            data_out_reg <= shift_next[0];
                            bit_idx_reg  <= bit_idx_reg + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
                            tx_done_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    data_out_reg <= STOP_BIT;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = idle;
    assign tx_busy  = !idle;
    assign data_out = data_out_reg;
    assign tx_done  = tx_done_reg;

endmodule
